// File: rtl/forward_unit.sv
// EX-stage operand forwarding with optional load-use stall detection.
// Define FWD_LOAD_STALL_EN to enable the load-use stall and its saturating counter.
module forward_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             IdValid,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic [4:0]       IdDst,
    input  logic             IdRegWrite,
    input  logic             IdMemRead,
    input  logic             Flush,
    output logic [1:0]       SelA,
    output logic [1:0]       SelB,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [1:0] SelRegFile = 2'd0;
    localparam logic [1:0] SelMemWb   = 2'd1;
    localparam logic [1:0] SelExMem   = 2'd2;

    // Producer slots: EX holds the instruction issued last cycle, MEM the one before.
    logic       exValidQ, exWrQ;
    logic [4:0] exDstQ;
    logic       memValidQ, memWrQ;
    logic [4:0] memDstQ;

    logic       exValidD, exWrD;
    logic [4:0] exDstD;
    logic [1:0] selAD, selBD;
    logic       issue;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic       exV,
        input logic       exW,
        input logic [4:0] exD,
        input logic       memV,
        input logic       memW,
        input logic [4:0] memD
    );
        logic [1:0] sel;
        sel = SelRegFile;
        // EX/MEM is checked last so it wins when both slots match.
        if (memV && memW && (memD != 5'd0) && (memD == src)) sel = SelMemWb;
        if (exV && exW && (exD != 5'd0) && (exD == src)) sel = SelExMem;
        return sel;
    endfunction

`ifdef FWD_LOAD_STALL_EN
    logic             exLoadQ, exLoadD;
    logic [CNT_W-1:0] cntQ, cntD;

    always_comb begin
        Stall = IdValid && exValidQ && exLoadQ && exWrQ && (exDstQ != 5'd0) &&
                ((exDstQ == IdRs) || (exDstQ == IdRt));
        cntD  = cntQ;
        if (Stall && (cntQ != {CNT_W{1'b1}})) cntD = cntQ + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exLoadQ <= 1'b0;
            cntQ    <= '0;
        end else begin
            exLoadQ <= exLoadD;
            cntQ    <= cntD;
        end
    end

    assign exLoadD    = issue && IdMemRead;
    assign StallCount = cntQ;
`else
    // Loads forward like any producer; software covers the load delay slot.
    logic unusedMemRead;
    assign unusedMemRead = IdMemRead;
    assign Stall         = 1'b0;
    assign StallCount    = '0;
`endif

    always_comb begin
        issue    = IdValid && !Stall && !Flush;
        exValidD = issue;
        exWrD    = issue && IdRegWrite;
        exDstD   = issue ? IdDst : 5'd0;
        selAD    = SelRegFile;
        selBD    = SelRegFile;
        if (issue) begin
            selAD = fwdSel(IdRs, exValidQ, exWrQ, exDstQ, memValidQ, memWrQ, memDstQ);
            selBD = fwdSel(IdRt, exValidQ, exWrQ, exDstQ, memValidQ, memWrQ, memDstQ);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exValidQ  <= 1'b0;
            exWrQ     <= 1'b0;
            exDstQ    <= 5'd0;
            memValidQ <= 1'b0;
            memWrQ    <= 1'b0;
            memDstQ   <= 5'd0;
            SelA      <= SelRegFile;
            SelB      <= SelRegFile;
        end else begin
            exValidQ  <= exValidD;
            exWrQ     <= exWrD;
            exDstQ    <= exDstD;
            memValidQ <= exValidQ;
            memWrQ    <= exWrQ;
            memDstQ   <= exDstQ;
            SelA      <= selAD;
            SelB      <= selBD;
        end
    end

endmodule
